// File: rtl/fpu_pkg.sv
// Shared types and constants for the floating-point compare pipeline.
// The NaN-aware compare behaviour is enabled with the FPU_CMP_NAN_EN macro.
package fpu_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LE  = 3'd2,
    OP_GE  = 3'd3,
    OP_LT  = 3'd4,
    OP_GT  = 3'd5,
    OP_MIN = 3'd6,
    OP_MAX = 3'd7
  } fpu_cmp_op_t;

  // Canonical quiet NaN: sign 0, exponent all ones, only the mantissa MSB set.
  function automatic logic [63:0] fpu_qnan(input int exp_w, input int man_w);
    logic [63:0] v;
    v = ((64'd1 << exp_w) - 64'd1) << man_w;
    v = v | (64'd1 << (man_w - 1));
    return v;
  endfunction

endpackage

// File: rtl/fpu_cmp_core.sv
// Combinational classify/compare/select for sign-magnitude floating-point operands.
// NaN detection and handling is compiled in only with FPU_CMP_NAN_EN.
module fpu_cmp_core
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W    = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a_data,
  input  logic [W-1:0] b_data,
  input  fpu_cmp_op_t  op,
  output logic [W-1:0] res,
  output logic         invalid
);

  logic [W-2:0] mag_a;
  logic [W-2:0] mag_b;
  logic         sign_a;
  logic         sign_b;
  logic         both_zero;
  logic         eq_s;
  logic         lt_s;
  logic         gt_s;

  assign sign_a    = a_data[W-1];
  assign sign_b    = b_data[W-1];
  assign mag_a     = a_data[W-2:0];
  assign mag_b     = b_data[W-2:0];
  assign both_zero = (mag_a == '0) && (mag_b == '0);
  assign eq_s      = both_zero || (a_data == b_data);
  assign gt_s      = !lt_s && !eq_s;

  // Sign-magnitude less-than; the two zeros never order against each other.
  always_comb begin
    lt_s = 1'b0;
    if (both_zero) begin
      lt_s = 1'b0;
    end else if (sign_a != sign_b) begin
      lt_s = sign_a;
    end else if (sign_a) begin
      lt_s = (mag_a > mag_b);
    end else begin
      lt_s = (mag_a < mag_b);
    end
  end

`ifdef FPU_CMP_NAN_EN
  logic a_nan;
  logic b_nan;
  logic [W-1:0] qnan_s;

  assign a_nan  = (&a_data[W-2:MAN_W]) && (|a_data[MAN_W-1:0]);
  assign b_nan  = (&b_data[W-2:MAN_W]) && (|b_data[MAN_W-1:0]);
  assign qnan_s = W'(fpu_qnan(EXP_W, MAN_W));
`endif

  // Result select; on equal operands MIN and MAX both return a_data.
  always_comb begin
    res     = '0;
    invalid = 1'b0;
    case (op)
      OP_EQ:   res[0] = eq_s;
      OP_NE:   res[0] = !eq_s;
      OP_LE:   res[0] = lt_s || eq_s;
      OP_GE:   res[0] = gt_s || eq_s;
      OP_LT:   res[0] = lt_s;
      OP_GT:   res[0] = gt_s;
      OP_MIN:  res    = gt_s ? b_data : a_data;
      OP_MAX:  res    = lt_s ? b_data : a_data;
      default: res    = '0;
    endcase
`ifdef FPU_CMP_NAN_EN
    if (a_nan || b_nan) begin
      case (op)
        OP_NE: res = {{(W-1){1'b0}}, 1'b1};
        OP_LE, OP_GE, OP_LT, OP_GT: begin
          res     = '0;
          invalid = 1'b1;
        end
        OP_MIN, OP_MAX: begin
          if (a_nan && b_nan) begin
            res = qnan_s;
          end else if (a_nan) begin
            res = b_data;
          end else begin
            res = a_data;
          end
        end
        default: res = '0;
      endcase
    end else begin
      invalid = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/fpu_cmp_pipe.sv
// Pipelined floating-point compare/min/max with valid/ready handshake and tag sideband.
// FPU_CMP_NAN_EN enables NaN-aware results and the m_invalid flag.
module fpu_cmp_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     a_data,
  input  logic [W-1:0]     b_data,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] s_tag,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_data,
  output logic [TAG_W-1:0] m_tag,
  output logic             m_invalid
);

  logic             advance_s;
  logic [W-1:0]     core_res_s;
  logic             core_inv_s;
  logic [LATENCY-1:0] vld_r;
  logic [LATENCY-1:0] inv_r;
  logic [W-1:0]       dat_r [LATENCY];
  logic [TAG_W-1:0]   tag_r [LATENCY];

  fpu_cmp_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .a_data  (a_data),
    .b_data  (b_data),
    .op      (fpu_cmp_op_t'(op)),
    .res     (core_res_s),
    .invalid (core_inv_s)
  );

  // The whole pipe moves as one; only a held output stalls it.
  assign advance_s = !m_valid || m_ready;
  assign s_ready   = advance_s;

  // Stage 0 captures the core result, later stages shift toward the output.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vld_r <= '0;
      inv_r <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat_r[i] <= '0;
        tag_r[i] <= '0;
      end
    end else if (advance_s) begin
      vld_r[0] <= s_valid;
      inv_r[0] <= core_inv_s;
      dat_r[0] <= core_res_s;
      tag_r[0] <= s_tag;
      for (int i = 1; i < LATENCY; i++) begin
        vld_r[i] <= vld_r[i-1];
        inv_r[i] <= inv_r[i-1];
        dat_r[i] <= dat_r[i-1];
        tag_r[i] <= tag_r[i-1];
      end
    end
  end

  assign m_valid   = vld_r[LATENCY-1];
  assign m_invalid = inv_r[LATENCY-1];
  assign m_data    = dat_r[LATENCY-1];
  assign m_tag     = tag_r[LATENCY-1];

endmodule

// File: tb/tb_fpu_cmp_pipe.sv
// Scoreboard bench for fpu_cmp_pipe: directed, random, backpressure and reset scenarios.
// Build with FPU_CMP_NAN_EN defined to exercise the NaN-aware variant.
module tb_fpu_cmp_pipe;

  localparam int L  = 2;
  localparam int W  = 32;
  localparam int TW = 5;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  a_data;
  logic [W-1:0]  b_data;
  logic [2:0]    op;
  logic [TW-1:0] s_tag;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [TW-1:0] m_tag;
  logic          m_invalid;

  fpu_cmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(L), .TAG_W(TW)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_valid(s_valid), .s_ready(s_ready),
    .a_data(a_data), .b_data(b_data), .op(op), .s_tag(s_tag),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
    .m_invalid(m_invalid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          inv;
    int            acc;
    bit            lat;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int stall_n = 0;
  logic [TW-1:0] tag_ctr = '0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: order operands by a signed integer key, which merges +0 and -0.
  function automatic longint key(input logic [W-1:0] x);
    longint m;
    m = longint'(x[W-2:0]);
    return x[W-1] ? -m : m;
  endfunction

  function automatic bit is_nan(input logic [W-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] o);
    longint ka = key(a);
    longint kb = key(b);
    logic [W-1:0] r = '0;
    logic inv = 1'b0;
    case (o)
      3'd0: r = (ka == kb) ? 32'd1 : 32'd0;
      3'd1: r = (ka != kb) ? 32'd1 : 32'd0;
      3'd2: r = (ka <= kb) ? 32'd1 : 32'd0;
      3'd3: r = (ka >= kb) ? 32'd1 : 32'd0;
      3'd4: r = (ka <  kb) ? 32'd1 : 32'd0;
      3'd5: r = (ka >  kb) ? 32'd1 : 32'd0;
      3'd6: r = (kb < ka) ? b : a;
      default: r = (ka < kb) ? b : a;
    endcase
`ifdef FPU_CMP_NAN_EN
    if (is_nan(a) || is_nan(b)) begin
      inv = (o >= 3'd2) && (o <= 3'd5);
      if (o == 3'd1) r = 32'd1;
      else if (o < 3'd6) r = 32'd0;
      else if (is_nan(a) && is_nan(b)) r = 32'h7FC00000;
      else r = is_nan(a) ? b : a;
    end
`endif
    return {inv, r};
  endfunction

  function automatic logic [W-1:0] rnd_operand(input logic [W-1:0] other);
    logic [W-1:0] v;
    case ($urandom_range(0, 6))
      0: v = {$urandom_range(0, 1) == 1, 31'd0};
      1: v = other;
      2: v = other ^ 32'h80000000;
      3: v = {$urandom_range(0, 1) == 1, 8'hFF, 23'($urandom_range(1, 8388607))};
      4: v = other + 32'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Present one beat, hold it until accepted, and log the expected response.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                       input bit use_c, input logic [W:0] c);
    exp_t e;
    logic [W:0] m;
    bit done = 1'b0;
    m = use_c ? c : model(a, b, o);
    @(negedge aclk);
    s_valid = 1'b1; a_data = a; b_data = b; op = o; s_tag = tag_ctr;
    for (int k = 0; k < 64; k++) begin
      #1;
      if (s_ready) begin
        e.data = m[W-1:0]; e.inv = m[W]; e.tag = tag_ctr;
        e.acc = cyc; e.lat = (rdy_mode == 0);
        sb_q.push_back(e);
        done = 1'b1;
        break;
      end
      @(negedge aclk);
    end
    if (!done) chk("accept_timeout", 64'd0, 64'd1);
    tag_ctr++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge aclk);
      s_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k = 0;
    rdy_mode = 0;
    idle(1);
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge aclk);
      k++;
    end
    chk("drain_empty", 64'(sb_q.size()), 64'd0);
    idle(2);
  endtask

  // Downstream ready generator.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(negedge aclk);
      if (rdy_mode != 3) stall_n = 0;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = ($urandom_range(0, 1) == 1);
        2: m_ready = 1'b0;
        3: begin
          if (m_valid && stall_n < 3) begin
            m_ready = 1'b0;
            stall_n++;
          end else begin
            m_ready = 1'b1;
          end
        end
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: handshake rule, hold stability, in-order retirement, latency.
  initial begin
    bit hold = 1'b0;
    logic [W-1:0] h_data;
    logic [TW-1:0] h_tag;
    logic h_inv;
    exp_t e;
    forever begin
      @(negedge aclk);
      #2;
      if (!aresetn) begin
        hold = 1'b0;
      end else begin
        chk("s_ready_rule", 64'(s_ready), 64'(!m_valid || m_ready));
        if (hold) begin
          chk("hold_valid", 64'(m_valid), 64'd1);
          chk("hold_data", 64'(m_data), 64'(h_data));
          chk("hold_tag", 64'(m_tag), 64'(h_tag));
          chk("hold_inv", 64'(m_invalid), 64'(h_inv));
        end
        hold = 1'b0;
        if (m_valid && !m_ready) begin
          hold = 1'b1;
          h_data = m_data; h_tag = m_tag; h_inv = m_invalid;
        end else if (m_valid) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_beat", 64'(m_tag), 64'hFFFF);
          end else begin
            e = sb_q.pop_front();
            chk("m_tag", 64'(m_tag), 64'(e.tag));
            chk("m_data", 64'(m_data), 64'(e.data));
            chk("m_invalid", 64'(m_invalid), 64'(e.inv));
            if (e.lat && rdy_mode == 0) chk("latency", 64'(cyc), 64'(e.acc + L));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   o;
    logic [W:0]   e;
  } vec_t;

  vec_t dir[$];
  logic [W-1:0] ra;
  logic [W-1:0] rb;

  initial begin
    aresetn = 1'b0; s_valid = 1'b0; a_data = '0; b_data = '0; op = 3'd0; s_tag = '0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_tag", 64'(m_tag), 64'd0);
    chk("rst_m_invalid", 64'(m_invalid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    aresetn = 1'b1;

    dir.push_back('{32'h3F800000, 32'h40000000, 3'd4, 33'h000000001});
    dir.push_back('{32'h3F800000, 32'h40000000, 3'd5, 33'h000000000});
    dir.push_back('{32'h3F800000, 32'h40000000, 3'd7, 33'h040000000});
    dir.push_back('{32'hBF800000, 32'hC0000000, 3'd5, 33'h000000001});
    dir.push_back('{32'hBF800000, 32'hC0000000, 3'd4, 33'h000000000});
    dir.push_back('{32'hBF800000, 32'hC0000000, 3'd6, 33'h0C0000000});
    dir.push_back('{32'h00000000, 32'h80000000, 3'd0, 33'h000000001});
    dir.push_back('{32'h00000000, 32'h80000000, 3'd1, 33'h000000000});
    dir.push_back('{32'h00000000, 32'h80000000, 3'd2, 33'h000000001});
    dir.push_back('{32'h00000000, 32'h80000000, 3'd4, 33'h000000000});
    dir.push_back('{32'h00000000, 32'h80000000, 3'd6, 33'h000000000});
    dir.push_back('{32'h80000000, 32'h00000000, 3'd7, 33'h080000000});
`ifdef FPU_CMP_NAN_EN
    dir.push_back('{32'h7FC00001, 32'h3F800000, 3'd0, 33'h000000000});
    dir.push_back('{32'h7FC00001, 32'h3F800000, 3'd1, 33'h000000001});
    dir.push_back('{32'h7FC00001, 32'h3F800000, 3'd4, 33'h100000000});
    dir.push_back('{32'h7FC00001, 32'h3F800000, 3'd7, 33'h03F800000});
    dir.push_back('{32'h7FC00001, 32'hFF800005, 3'd6, 33'h07FC00000});
`else
    dir.push_back('{32'h7FC00001, 32'h3F800000, 3'd5, 33'h000000001});
    dir.push_back('{32'hFFC00000, 32'h3F800000, 3'd7, 33'h03F800000});
`endif
    rdy_mode = 0;
    foreach (dir[i]) issue(dir[i].a, dir[i].b, dir[i].o, 1'b1, dir[i].e);
    drain();

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = rnd_operand(ra);
      issue(ra, rb, 3'($urandom_range(0, 7)), 1'b0, '0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      ra = rnd_operand($urandom);
      rb = rnd_operand(ra);
      issue(ra, rb, 3'($urandom_range(0, 7)), 1'b0, '0);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Six back-to-back beats, output stalled for three cycles once the first appears.
    tag_ctr = '0;
    rdy_mode = 3;
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, 3'($urandom_range(0, 7)), 1'b0, '0);
    end
    drain();
    chk("bp_stall_cycles", 64'(stall_n), 64'd0);

    // Reset with two beats in flight: both are discarded.
    rdy_mode = 2;
    issue(32'h3F800000, 32'h40000000, 3'd4, 1'b0, '0);
    issue(32'h40000000, 32'h3F800000, 3'd4, 1'b0, '0);
    @(negedge aclk);
    s_valid = 1'b0;
    aresetn = 1'b0;
    sb_q.delete();
    @(negedge aclk);
    #1;
    chk("rst2_m_valid", 64'(m_valid), 64'd0);
    chk("rst2_m_data", 64'(m_data), 64'd0);
    chk("rst2_m_tag", 64'(m_tag), 64'd0);
    chk("rst2_m_invalid", 64'(m_invalid), 64'd0);
    aresetn = 1'b1;
    rdy_mode = 0;
    @(negedge aclk);
    #1;
    chk("rst2_s_ready", 64'(s_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      #1;
      chk("rst2_no_valid", 64'(m_valid), 64'd0);
    end
    issue(32'hBF800000, 32'hC0000000, 3'd5, 1'b1, 33'h000000001);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
